// File: rtl/hud_sprite_rom_bank.sv
`default_nettype none
// ============================================================================
// Module   : hud_sprite_rom_bank
// Brief    : Three independent 1-cycle-latency sprite ROMs for the HUD
//            (full heart, empty heart outline, seven-segment digits 0-9).
// Revision : 1.0 - initial release
// ============================================================================
module hud_sprite_rom_bank #(
    parameter logic [7:0] TRANSPARENT   = 8'hBB,
    parameter logic [7:0] HEART_COLOR   = 8'hE0,
    parameter logic [7:0] OUTLINE_COLOR = 8'hB6,
    parameter logic [7:0] DIGIT_COLOR   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] life_row,
    input  logic [3:0] life_col,
    output logic [7:0] life_full_data,
    output logic [7:0] life_empty_data,
    input  logic [6:0] digit_row,
    input  logic [3:0] digit_col,
    output logic [7:0] digit_data
);

    localparam logic [7:0] c_RESET_PIXEL = 8'h00;

    // Bit c of the returned word is heart column c.
    function automatic logic [13:0] heart_row_mask(input logic [3:0] row);
        logic [13:0] m;
        case (row)
            4'd0:                m = 14'b00111000011100;
            4'd1:                m = 14'b01111100111110;
            4'd2, 4'd3, 4'd4:    m = 14'b11111111111111;
            4'd5:                m = 14'b01111111111110;
            4'd6:                m = 14'b00111111111100;
            4'd7:                m = 14'b00011111111000;
            4'd8:                m = 14'b00000111100000;
            4'd9:                m = 14'b00000011000000;
            default:             m = 14'b00000000000000;
        endcase
        return m;
    endfunction

    function automatic logic heart_px(input int row, input int col);
        logic [13:0] m;
        logic [3:0]  r4;
        logic [3:0]  c4;
        m  = 14'd0;
        r4 = row[3:0];
        c4 = col[3:0];
        if (row < 0 || row > 9 || col < 0 || col > 13) begin
            return 1'b0;
        end
        m = heart_row_mask(r4);
        return m[c4];
    endfunction

    // Neighbours off the grid count as outside, so cell-edge pixels fall out naturally.
    function automatic logic heart_outline(input int row, input int col);
        return heart_px(row, col) &&
               (!heart_px(row - 1, col) || !heart_px(row + 1, col) ||
                !heart_px(row, col - 1) || !heart_px(row, col + 1));
    endfunction

    // Lit-segment mask per digit, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] digit_segments(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic digit_px(input logic [6:0] row, input logic [3:0] col);
        int         ri;
        logic [3:0] d;
        logic [3:0] r;
        logic       mid_c;
        logic       left_c;
        logic       right_c;
        logic [6:0] hit;
        ri      = int'(row);
        d       = 4'(ri / 12);
        r       = 4'(ri % 12);
        mid_c   = (col >= 4'd2) && (col <= 4'd11);
        left_c  = (col <= 4'd1);
        right_c = (col == 4'd12) || (col == 4'd13);
        hit[0]  = (r <= 4'd1) && mid_c;                         // a
        hit[1]  = (r >= 4'd2) && (r <= 4'd4) && right_c;        // b
        hit[2]  = (r >= 4'd7) && (r <= 4'd9) && right_c;        // c
        hit[3]  = (r >= 4'd10) && mid_c;                        // d
        hit[4]  = (r >= 4'd7) && (r <= 4'd9) && left_c;         // e
        hit[5]  = (r >= 4'd2) && (r <= 4'd4) && left_c;         // f
        hit[6]  = (r >= 4'd5) && (r <= 4'd6) && mid_c;          // g
        if (row > 7'd119 || col > 4'd13) begin
            return 1'b0;
        end
        return |(hit & digit_segments(d));
    endfunction

    logic [7:0] w_life_full_d;
    logic [7:0] w_life_empty_d;
    logic [7:0] w_digit_d;

    // Power-up value for FPGA targets; reset loads the same value afterwards.
    logic [7:0] r_life_full_q  = c_RESET_PIXEL;
    logic [7:0] r_life_empty_q = c_RESET_PIXEL;
    logic [7:0] r_digit_q      = c_RESET_PIXEL;

    always_comb begin
        w_life_full_d  = TRANSPARENT;
        w_life_empty_d = TRANSPARENT;
        w_digit_d      = TRANSPARENT;
        if (heart_px(int'(life_row), int'(life_col))) begin
            w_life_full_d = HEART_COLOR;
        end
        if (heart_outline(int'(life_row), int'(life_col))) begin
            w_life_empty_d = OUTLINE_COLOR;
        end
        if (digit_px(digit_row, digit_col)) begin
            w_digit_d = DIGIT_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_life_full_q  <= c_RESET_PIXEL;
            r_life_empty_q <= c_RESET_PIXEL;
            r_digit_q      <= c_RESET_PIXEL;
        end else begin
            r_life_full_q  <= w_life_full_d;
            r_life_empty_q <= w_life_empty_d;
            r_digit_q      <= w_digit_d;
        end
    end

    assign life_full_data  = r_life_full_q;
    assign life_empty_data = r_life_empty_q;
    assign digit_data      = r_digit_q;

endmodule
`default_nettype wire

// File: tb/tb_hud_sprite_rom_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hud_sprite_rom_bank
// Brief    : Directed and exhaustive scoreboard bench for hud_sprite_rom_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hud_sprite_rom_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] life_row = 4'd0;
    logic [3:0] life_col = 4'd0;
    logic [6:0] digit_row = 7'd0;
    logic [3:0] digit_col = 4'd0;
    logic [7:0] life_full_data;
    logic [7:0] life_empty_data;
    logic [7:0] digit_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] full;
        logic [7:0] empty;
        logic [7:0] digit;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    hud_sprite_rom_bank dut (
        .clk             (clk),
        .rst             (rst),
        .life_row        (life_row),
        .life_col        (life_col),
        .life_full_data  (life_full_data),
        .life_empty_data (life_empty_data),
        .digit_row       (digit_row),
        .digit_col       (digit_col),
        .digit_data      (digit_data)
    );

    always #5 clk = ~clk;

    string heart_art[10] = '{
        "..###....###..",
        ".#####..#####.",
        "##############",
        "##############",
        "##############",
        ".############.",
        "..##########..",
        "...########...",
        ".....####.....",
        "......##......"
    };

    string digit_segs[10] = '{
        "abcdef", "bc", "abdeg", "abcdg", "bcfg",
        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"
    };

    function automatic bit m_heart(input int r, input int c);
        if (r < 0 || r > 9 || c < 0 || c > 13) return 1'b0;
        return heart_art[r].getc(c) == 8'h23;
    endfunction

    function automatic bit m_outline(input int r, input int c);
        if (!m_heart(r, c)) return 1'b0;
        if (r == 0 || r == 9 || c == 0 || c == 13) return 1'b1;
        return !m_heart(r - 1, c) || !m_heart(r + 1, c) ||
               !m_heart(r, c - 1) || !m_heart(r, c + 1);
    endfunction

    function automatic bit m_digit(input int row, input int c);
        int    d;
        int    r;
        byte   seg;
        string s;
        if (row > 119 || c > 13) return 1'b0;
        d   = row / 12;
        r   = row % 12;
        seg = 8'h00;
        if (r <= 1 && c >= 2 && c <= 11)                  seg = "a";
        else if (r >= 2 && r <= 4 && c >= 12)             seg = "b";
        else if (r >= 7 && r <= 9 && c >= 12)             seg = "c";
        else if (r >= 10 && c >= 2 && c <= 11)            seg = "d";
        else if (r >= 7 && r <= 9 && c <= 1)              seg = "e";
        else if (r >= 2 && r <= 4 && c <= 1)              seg = "f";
        else if (r >= 5 && r <= 6 && c >= 2 && c <= 11)   seg = "g";
        if (seg == 8'h00) return 1'b0;
        s = digit_segs[d];
        for (int k = 0; k < s.len(); k++) begin
            if (s.getc(k) == seg) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one address set, push its expectation, and compare after the edge.
    task automatic step(input logic [3:0] lr, input logic [3:0] lc,
                        input logic [6:0] dr, input logic [3:0] dc, input logic r,
                        input logic [7:0] ef, input logic [7:0] ee, input logic [7:0] ed,
                        input string tag);
        exp_t e;
        life_row  = lr;
        life_col  = lc;
        digit_row = dr;
        digit_col = dc;
        rst       = r;
        e.full  = ef;
        e.empty = ee;
        e.digit = ed;
        e.tag   = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check8({e.tag, "_full"},  life_full_data,  e.full);
        check8({e.tag, "_empty"}, life_empty_data, e.empty);
        check8({e.tag, "_digit"}, digit_data,      e.digit);
    endtask

    task automatic step_model(input logic [3:0] lr, input logic [3:0] lc,
                              input logic [6:0] dr, input logic [3:0] dc, input string tag);
        logic [7:0] ef;
        logic [7:0] ee;
        logic [7:0] ed;
        ef = m_heart(int'(lr), int'(lc))   ? 8'hE0 : 8'hBB;
        ee = m_outline(int'(lr), int'(lc)) ? 8'hB6 : 8'hBB;
        ed = m_digit(int'(dr), int'(dc))   ? 8'hFF : 8'hBB;
        step(lr, lc, dr, dc, 1'b0, ef, ee, ed, tag);
    endtask

    initial begin
        #1;
        check8("powerup_full",  life_full_data,  8'h00);
        check8("powerup_empty", life_empty_data, 8'h00);
        check8("powerup_digit", digit_data,      8'h00);

        step(4'd3, 4'd6, 7'd101, 4'd6, 1'b1, 8'h00, 8'h00, 8'h00, "reset");
        step(4'd3, 4'd6, 7'd101, 4'd6, 1'b0, 8'hE0, 8'hBB, 8'hFF, "interior_d8g");
        step(4'd0, 4'd0, 7'd5,   4'd6, 1'b0, 8'hBB, 8'hBB, 8'hBB, "corner_d0g");
        step(4'd0, 4'd3, 7'd14,  4'd12, 1'b0, 8'hE0, 8'hB6, 8'hFF, "edge_d1b");
        step(4'd3, 4'd14, 7'd14, 4'd0, 1'b0, 8'hBB, 8'hBB, 8'hBB, "col14_d1f");
        step(4'd10, 4'd5, 7'd120, 4'd6, 1'b0, 8'hBB, 8'hBB, 8'hBB, "row_oor");
        step(4'd8, 4'd5, 7'd0,   4'd0, 1'b0, 8'hE0, 8'hB6, 8'hBB, "tip_corner");
        step(4'd5, 4'd6, 7'd31,  4'd13, 1'b0, 8'hE0, 8'hBB, 8'hBB, "d2_c_unlit");

        for (int i = 0; i < 2048; i++) begin
            int         j;
            logic [3:0] lr;
            logic [3:0] lc;
            logic [6:0] dr;
            logic [3:0] dc;
            j  = (i * 37) & 255;
            lr = 4'(j >> 4);
            lc = 4'(j & 15);
            dr = 7'(i >> 4);
            dc = 4'(i & 15);
            if (i == 1000) begin
                step(lr, lc, dr, dc, 1'b1, 8'h00, 8'h00, 8'h00, "sweep_reset");
            end
            step_model(lr, lc, dr, dc, "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
